// File: rtl/decode_pkg.sv
// Shared decode-stage types and instruction field positions.
// Imported by the decode/issue stage and its operand bypass.
package decode_pkg;

  localparam int REG_AW   = 3;
  localparam int RS1_HI   = 10;
  localparam int RS1_LO   = 8;
  localparam int RS2_HI   = 7;
  localparam int RS2_LO   = 5;
  localparam int SHAMT_HI = 3;
  localparam int SHAMT_LO = 0;

  typedef enum logic {
    RUN,
    IMM
  } state_e;

  typedef enum logic [2:0] {
    A_KEEP,
    A_FLUSH,
    A_BUBBLE,
    A_ISSUE,
    A_SAVE,
    A_ISSUE_SV
  } act_e;

  function automatic logic [REG_AW-1:0] rs1_of(
    input logic [15:0] w
  );
    return w[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [REG_AW-1:0] rs2_of(
    input logic [15:0] w
  );
    return w[RS2_HI:RS2_LO];
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// One register read port with write-back forwarding.
// Fresh write-back data overrides the register file value.
module operand_bypass
  import decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [REG_AW-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

  logic hit;

  assign hit  = wb_we & (wb_addr == raddr);
  assign data = hit ? wb_data : rdata;

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: operand read with bypass, load-use
// interlock, two-word immediate assembly, ID/EX register.
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic              dec_uses_rs1,
  input  logic              dec_uses_rs2,
  input  logic              dec_two_word,
  input  logic              dec_mem_read,
  output logic [2:0]        rf_raddr1,
  output logic [2:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_fetch,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [2:0]        ex_rd,
  output logic [3:0]        ex_shamt,
  output logic              ex_mem_read
);

  state_e state_q;
  act_e   act;

  logic [CTRL_W-1:0] sv_ctrl;
  logic [PC_W-1:0]   sv_pc;
  logic [2:0]        sv_rd;
  logic [3:0]        sv_shamt;
  logic              sv_mem_read;
  logic [DATA_W-1:0] sv_rs1;
  logic [DATA_W-1:0] sv_rs2;
  logic [2:0]        sv_ra1;
  logic [2:0]        sv_ra2;

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] sop1;
  logic [DATA_W-1:0] sop2;

  logic hit1;
  logic hit2;
  logic hazard;

  logic [CTRL_W-1:0] nx_ctrl;
  logic [PC_W-1:0]   nx_pc;
  logic [DATA_W-1:0] nx_rs1;
  logic [DATA_W-1:0] nx_rs2;
  logic [DATA_W-1:0] nx_imm;
  logic [2:0]        nx_rd;
  logic [3:0]        nx_shamt;
  logic              nx_mem_read;
  logic              pkt_ld;
  logic              pkt_clr;
  logic              from_sv;

  assign rf_raddr1 = rs1_of(if_instr);
  assign rf_raddr2 = rs2_of(if_instr);

  operand_bypass #(.DATA_W(DATA_W)) u_byp1 (
    .raddr   (rf_raddr1),
    .rdata   (rf_rdata1),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .data    (op1)
  );

  operand_bypass #(.DATA_W(DATA_W)) u_byp2 (
    .raddr   (rf_raddr2),
    .rdata   (rf_rdata2),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .data    (op2)
  );

  // Saved operands may be overwritten while waiting for the imm word.
  operand_bypass #(.DATA_W(DATA_W)) u_sbyp1 (
    .raddr   (sv_ra1),
    .rdata   (sv_rs1),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .data    (sop1)
  );

  operand_bypass #(.DATA_W(DATA_W)) u_sbyp2 (
    .raddr   (sv_ra2),
    .rdata   (sv_rs2),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .data    (sop2)
  );

  assign hit1 = dec_uses_rs1 & (ex_rd == rf_raddr1);
  assign hit2 = dec_uses_rs2 & (ex_rd == rf_raddr2);

  assign hazard = (state_q == RUN) & ex_valid & ex_mem_read
                & if_valid & (hit1 | hit2);

  assign stall_fetch = ~reset & ~flush & (hold | hazard);

  always_comb begin
    act = A_BUBBLE;
    priority case (1'b1)
      flush:  act = A_FLUSH;
      hold:   act = A_KEEP;
      hazard: act = A_BUBBLE;
      (state_q == RUN) & if_valid & ~dec_two_word:
        act = A_ISSUE;
      (state_q == RUN) & if_valid & dec_two_word:
        act = A_SAVE;
      (state_q == IMM) & if_valid:
        act = A_ISSUE_SV;
      default: act = A_BUBBLE;
    endcase
  end

  assign from_sv = (act == A_ISSUE_SV);
  assign pkt_ld  = (act == A_ISSUE) | from_sv;
  assign pkt_clr = (act == A_FLUSH) | (act == A_BUBBLE)
                 | (act == A_SAVE);

  always_comb begin
    nx_ctrl     = dec_ctrl;
    nx_pc       = if_pc;
    nx_rs1      = op1;
    nx_rs2      = op2;
    nx_imm      = '0;
    nx_rd       = rf_raddr1;
    nx_shamt    = if_instr[SHAMT_HI:SHAMT_LO];
    nx_mem_read = dec_mem_read;
    if (from_sv) begin
      nx_ctrl     = sv_ctrl;
      nx_pc       = sv_pc;
      nx_rs1      = sop1;
      nx_rs2      = sop2;
      nx_imm      = DATA_W'(if_instr);
      nx_rd       = sv_rd;
      nx_shamt    = sv_shamt;
      nx_mem_read = sv_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      unique case (act)
        A_FLUSH:    state_q <= RUN;
        A_SAVE:     state_q <= IMM;
        A_ISSUE_SV: state_q <= RUN;
        default:    state_q <= state_q;
      endcase
    end
  end

  // First word of a two-word instruction, held until its immediate.
  always_ff @(posedge clk) begin
    if (reset) begin
      sv_ctrl     <= '0;
      sv_pc       <= '0;
      sv_rd       <= '0;
      sv_shamt    <= '0;
      sv_mem_read <= 1'b0;
      sv_rs1      <= '0;
      sv_rs2      <= '0;
      sv_ra1      <= '0;
      sv_ra2      <= '0;
    end else if (act == A_SAVE) begin
      sv_ctrl     <= dec_ctrl;
      sv_pc       <= if_pc;
      sv_rd       <= rf_raddr1;
      sv_shamt    <= if_instr[SHAMT_HI:SHAMT_LO];
      sv_mem_read <= dec_mem_read;
      sv_rs1      <= op1;
      sv_rs2      <= op2;
      sv_ra1      <= rf_raddr1;
      sv_ra2      <= rf_raddr2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_shamt    <= '0;
      ex_mem_read <= 1'b0;
    end else if (pkt_clr) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_mem_read <= 1'b0;
    end else if (pkt_ld) begin
      ex_valid    <= 1'b1;
      ex_ctrl     <= nx_ctrl;
      ex_pc       <= nx_pc;
      ex_rs1_data <= nx_rs1;
      ex_rs2_data <= nx_rs2;
      ex_imm      <= nx_imm;
      ex_rd       <= nx_rd;
      ex_shamt    <= nx_shamt;
      ex_mem_read <= nx_mem_read;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage.
// Hand-computed expectations checked with immediate assertions.
module tb_decode_issue_stage;

  localparam int DATA_W = 16;
  localparam int PC_W   = 32;
  localparam int CTRL_W = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [PC_W-1:0]   if_pc;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  logic              dec_two_word;
  logic              dec_mem_read;
  logic [2:0]        rf_raddr1;
  logic [2:0]        rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              wb_we;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              hold;
  logic              stall_fetch;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_rs1_data;
  logic [DATA_W-1:0] ex_rs2_data;
  logic [DATA_W-1:0] ex_imm;
  logic [2:0]        ex_rd;
  logic [3:0]        ex_shamt;
  logic              ex_mem_read;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W),
    .CTRL_W(CTRL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .dec_ctrl    (dec_ctrl),
    .dec_uses_rs1(dec_uses_rs1),
    .dec_uses_rs2(dec_uses_rs2),
    .dec_two_word(dec_two_word),
    .dec_mem_read(dec_mem_read),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .hold        (hold),
    .stall_fetch (stall_fetch),
    .ex_valid    (ex_valid),
    .ex_ctrl     (ex_ctrl),
    .ex_pc       (ex_pc),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_imm      (ex_imm),
    .ex_rd       (ex_rd),
    .ex_shamt    (ex_shamt),
    .ex_mem_read (ex_mem_read)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] rd,
                                     input logic [2:0] rs2,
                                     input logic [3:0] sh);
    return {5'b0, rd, rs2, 1'b0, sh};
  endfunction

  initial begin
    // reset with every input active
    reset = 1; if_valid = 1; if_instr = 16'hFFFF;
    if_pc = 32'hFFFF_FFFF; dec_ctrl = '1;
    dec_uses_rs1 = 1; dec_uses_rs2 = 1;
    dec_two_word = 1; dec_mem_read = 1;
    rf_rdata1 = 16'hAAAA; rf_rdata2 = 16'h5555;
    wb_we = 1; wb_addr = 3'd7; wb_data = 16'h7777;
    flush = 1; hold = 1;
    #1;
    chk("rst_stall", stall_fetch, 0);
    tick();
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_rs1", ex_rs1_data, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_memrd", ex_mem_read, 0);
    chk("rst_stall2", stall_fetch, 0);

    // single-word ADD
    reset = 0; flush = 0; hold = 0; wb_we = 0;
    dec_two_word = 0; dec_mem_read = 0;
    if_instr = mk(3'd3, 3'd5, 4'd2); if_pc = 32'h100;
    dec_ctrl = 24'h0000A1;
    rf_rdata1 = 16'h0011; rf_rdata2 = 16'h0022;
    #1;
    chk("raddr1", rf_raddr1, 3);
    chk("raddr2", rf_raddr2, 5);
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_ctrl", ex_ctrl, 24'hA1);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_rs1", ex_rs1_data, 16'h0011);
    chk("add_rs2", ex_rs2_data, 16'h0022);
    chk("add_rd", ex_rd, 3);
    chk("add_sh", ex_shamt, 2);
    chk("add_imm", ex_imm, 0);

    // load R2 then dependent ADD R3,R2
    if_instr = mk(3'd2, 3'd0, 4'd0); if_pc = 32'h104;
    dec_ctrl = 24'h0000B2; dec_mem_read = 1;
    dec_uses_rs2 = 0;
    tick();
    chk("ld_valid", ex_valid, 1);
    chk("ld_memrd", ex_mem_read, 1);
    chk("ld_rd", ex_rd, 2);
    if_instr = mk(3'd3, 3'd2, 4'd0); if_pc = 32'h108;
    dec_ctrl = 24'h0000C3; dec_mem_read = 0;
    dec_uses_rs2 = 1;
    #1;
    chk("lu_stall", stall_fetch, 1);
    tick();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_ctrl", ex_ctrl, 0);
    chk("lu_bub_memrd", ex_mem_read, 0);
    chk("lu_stall_clr", stall_fetch, 0);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_ctrl", ex_ctrl, 24'hC3);
    chk("lu_add_pc", ex_pc, 32'h108);

    // write-back bypass on rs1
    wb_we = 1; wb_addr = 3'd4; wb_data = 16'h1234;
    rf_rdata1 = 16'h0000; rf_rdata2 = 16'h0055;
    if_instr = mk(3'd4, 3'd1, 4'd0); dec_ctrl = 24'h000033;
    tick();
    chk("byp_rs1", ex_rs1_data, 16'h1234);
    chk("byp_rs2", ex_rs2_data, 16'h0055);

    // two-word LDM R1, 0xBEEF
    wb_we = 0;
    if_instr = mk(3'd1, 3'd0, 4'd0); if_pc = 32'h200;
    dec_ctrl = 24'h0000D4; dec_two_word = 1;
    rf_rdata1 = 16'h0077; rf_rdata2 = 16'h0066;
    #1;
    chk("ldm_stall", stall_fetch, 0);
    tick();
    chk("ldm_bub", ex_valid, 0);
    if_instr = 16'hBEEF; if_pc = 32'h204;
    dec_ctrl = 24'hFFFFFF; dec_two_word = 0; dec_mem_read = 1;
    tick();
    chk("ldm_valid", ex_valid, 1);
    chk("ldm_imm", ex_imm, 16'hBEEF);
    chk("ldm_rd", ex_rd, 1);
    chk("ldm_ctrl", ex_ctrl, 24'hD4);
    chk("ldm_pc", ex_pc, 32'h200);
    chk("ldm_rs1", ex_rs1_data, 16'h0077);
    chk("ldm_memrd", ex_mem_read, 0);

    // flush while in IMM
    dec_mem_read = 0;
    if_instr = mk(3'd5, 3'd0, 4'd0); if_pc = 32'h300;
    dec_ctrl = 24'h0000E5; dec_two_word = 1;
    tick();
    if_instr = 16'h0123; if_pc = 32'h304;
    dec_two_word = 0; dec_ctrl = 24'h0000F6; flush = 1;
    tick();
    chk("fl_valid", ex_valid, 0);
    chk("fl_ctrl", ex_ctrl, 0);
    flush = 0;
    tick();
    chk("fl_next_valid", ex_valid, 1);
    chk("fl_next_ctrl", ex_ctrl, 24'hF6);
    chk("fl_next_imm", ex_imm, 0);
    chk("fl_next_rd", ex_rd, 1);
    chk("fl_next_sh", ex_shamt, 3);

    // hold for three cycles
    hold = 1; if_instr = mk(3'd7, 3'd7, 4'd9);
    if_pc = 32'h400; dec_ctrl = 24'h000099;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", stall_fetch, 1);
      tick();
      chk("hold_valid", ex_valid, 1);
      chk("hold_ctrl", ex_ctrl, 24'hF6);
      chk("hold_pc", ex_pc, 32'h304);
      chk("hold_rd", ex_rd, 1);
    end
    hold = 0;

    // flush and hazard in the same cycle
    if_instr = mk(3'd2, 3'd0, 4'd0); dec_ctrl = 24'h000011;
    dec_mem_read = 1; dec_uses_rs2 = 0;
    tick();
    chk("ld2_memrd", ex_mem_read, 1);
    if_instr = mk(3'd2, 3'd0, 4'd0); dec_mem_read = 0;
    flush = 1;
    #1;
    chk("flhz_stall", stall_fetch, 0);
    tick();
    chk("flhz_valid", ex_valid, 0);
    flush = 0;

    // reset in the middle of IMM
    if_instr = mk(3'd6, 3'd0, 4'd0); dec_ctrl = 24'h000022;
    dec_two_word = 1;
    tick();
    if_instr = 16'h4321; dec_two_word = 0; reset = 1;
    tick();
    chk("rimm_valid", ex_valid, 0);
    reset = 0;
    if_instr = mk(3'd5, 3'd0, 4'd1); dec_ctrl = 24'h000044;
    tick();
    chk("rimm_next_valid", ex_valid, 1);
    chk("rimm_next_imm", ex_imm, 0);
    chk("rimm_next_rd", ex_rd, 5);

    // IMM waits on !if_valid; saved rs1 rebypassed
    if_instr = mk(3'd6, 3'd0, 4'd0); dec_ctrl = 24'h000055;
    dec_two_word = 1; rf_rdata1 = 16'h0010; if_pc = 32'h500;
    tick();
    if_valid = 0; dec_two_word = 0;
    tick();
    chk("wait_valid", ex_valid, 0);
    if_valid = 1; if_instr = 16'h00AA;
    wb_we = 1; wb_addr = 3'd6; wb_data = 16'h9999;
    tick();
    chk("wait_issue", ex_valid, 1);
    chk("wait_imm", ex_imm, 16'h00AA);
    chk("wait_ctrl", ex_ctrl, 24'h55);
    chk("wait_rebyp", ex_rs1_data, 16'h9999);
    wb_we = 0;

    // fetch idle in RUN gives a bubble
    if_valid = 0;
    tick();
    chk("idle_valid", ex_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised decode/issue stage for the pipelined processor, placed between fetch and execute, with a registered ID/EX boundary. It takes the fetched instruction and the control unit's decoded control bundle and reads the register file operands. Write-back data is bypassed into the operand read. Load-use hazards are interlocked by inserting one bubble. Two-word instructions (LDM-style immediate) are assembled through a small state machine. Each issued packet is registered toward execute, with flush, downstream-hold and bubble insertion.

## Interface
- DATA_W, 16: register/operand and immediate width
- PC_W, 32: program-counter width
- CTRL_W, 24: width of the opaque control bundle from the control unit (passed through, zeroed on bubble)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents a valid word this cycle
- if_instr  in  16  fetched word; [10:8] rs1/rd, [7:5] rs2, [3:0] shamt
- if_pc  in  PC_W  PC of if_instr
- dec_ctrl  in  CTRL_W  control bundle decoded from if_instr
- dec_uses_rs1, dec_uses_rs2  in  1 each  instruction reads rs1 / rs2
- dec_two_word  in  1  instruction's immediate follows in the next fetched word
- dec_mem_read  in  1  instruction is a load
- rf_raddr1, rf_raddr2  out  3 each  register file read addresses (combinational from if_instr)
- rf_rdata1, rf_rdata2  in  DATA_W each  combinational register file read data
- wb_we  in  1; wb_addr  in  3; wb_data  in  DATA_W  write-back port (for bypass)
- flush  in  1  squash in-flight decode state and output packet
- hold  in  1  downstream stall; freeze all state
- stall_fetch  out  1  fetch must not advance this cycle
- ex_valid  out  1  issued packet valid
- ex_ctrl  out  CTRL_W; ex_pc  out  PC_W; ex_rs1_data, ex_rs2_data  out  DATA_W; ex_imm  out  DATA_W; ex_rd  out  3; ex_shamt  out  4; ex_mem_read  out  1

## Operation
- States: RUN, IMM. Reset → RUN.
- Hazard (combinational): ex_valid & ex_mem_read & if_valid & ((dec_uses_rs1 & ex_rd==if_instr[10:8]) | (dec_uses_rs2 & ex_rd==if_instr[7:5])); evaluated only in RUN.
- Bypass: operand = wb_data when wb_we & wb_addr==read address, else rf_rdata.
- Priority per cycle: reset > flush > hold > hazard > normal.
- flush: state→RUN, ex_valid←0, ex_ctrl←0, ex_mem_read←0; saved first word discarded.
- hold: all registers keep value; stall_fetch=1.
- RUN, hazard: bubble (ex_valid←0, ex_ctrl←0, ex_mem_read←0), stall_fetch=1; same word re-presented next cycle.
- RUN, if_valid, !dec_two_word: issue packet: ex_valid←1, ex_ctrl←dec_ctrl, ex_pc←if_pc, operands (bypassed), ex_rd←[10:8], ex_shamt←[3:0], ex_mem_read←dec_mem_read, ex_imm←0.
- RUN, if_valid, dec_two_word: save ctrl, pc, rd, shamt, mem_read, bypassed operands; insert bubble; →IMM. stall_fetch=0.
- RUN, !if_valid: bubble.
- IMM, if_valid: issue saved packet, ex_imm←if_instr (zero-extended to DATA_W), saved operands re-bypassed against wb if wb_addr matches; →RUN. dec_* ignored.
- IMM, !if_valid: bubble, stay IMM.
- stall_fetch = hold | hazard (RUN only).

## Timing
- Reset: every output register 0, state RUN; stall_fetch=0 while reset held.
- Latency: single-word issue 1 cycle after if_valid; two-word issue 1 cycle after the second word (2 cycles total).
- Load-use: exactly one bubble; next cycle ex_mem_read=0 so hazard clears.
- flush and hazard same cycle: flush wins, stall_fetch=hazard is suppressed (0).
- flush in IMM: saved packet lost, immediate word not consumed.
- Reset mid-IMM: returns to RUN, nothing issued.

## Structure
- Package decode_pkg: state enum (RUN, IMM), field position constants (RS1_HI/LO, RS2_HI/LO, SHAMT_HI/LO), REG_AW=3.
- Sub-module operand_bypass (DATA_W parameter): one read port's wb-bypass mux; instanced twice plus twice for saved operands.
- Output packet register: single registered bundle with clear and enable.

## Test plan
- Reset with all inputs active → all ex_* 0, stall_fetch 0, next cycle single-word ADD issues with ex_valid=1.
- Load R2 issued, next word ADD R3,R2 (uses rs2=2) → stall_fetch=1 one cycle, bubble, ADD issues following cycle.
- Two-word LDM R1, imm 0xBEEF → bubble, then ex_valid=1, ex_imm=0xBEEF, ex_rd=1.
- wb_we=1, wb_addr=4, wb_data=0x1234, rf_rdata1=0, if_instr rs1=4 → ex_rs1_data=0x1234.
- flush while in IMM → ex_valid=0, state RUN, next word decoded as an instruction.
- hold=1 for 3 cycles with packet issued → ex_* unchanged, stall_fetch=1 each cycle.
